tt_um_quick_cpu: RTL and testbench

- Minimal 8-bit accumulator CPU packaged as a TinyTapeout user tile.
- Executes a program from a 32x8 internal unified program/data RAM.
- Drives an output register on uo_out and exposes debug status on uio_out.
- Internal signals pc (program counter) and rst (active-high reset) are required by name for hierarchical probing; the RAM array is instance m.m, array data.

---
 rtl/tt_um_quick_cpu.sv | 217 +++++++++++++++++++++
 tb/tb_tt_um_quick_cpu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_quick_cpu.sv
// tt_um_quick_cpu: 8-bit accumulator CPU packaged as a TinyTapeout user tile.
// The program and its data share one 32x8 RAM, so code can modify itself.
// Each instruction takes two cycles: FETCH, then EXEC.
//   clk      rising-edge system clock
//   rst_n    reset pin; internally rst = ~rst_n, synchronous, active-high
//   ena      tile enable (ignored)
//   ui_in    data read by the IN instruction
//   uo_out   output register, written by OUT
//   uio_in   unused
//   uio_out  status: [4:0] pc, [5] zero, [6] state (1 = exec), [7] halted
//   uio_oe   tied to 8'hFF

// RAM with asynchronous reads and a synchronous write. The power-up contents
// hold the default program.
//   clk              write clock
//   we/waddr/wdata   write port
//   raddr_a/rdata_a  instruction read port
//   raddr_b/rdata_b  operand read port
module quick_cpu_ram #(
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic       clk,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [4:0] raddr_b,
    output logic [7:0] rdata_b
);
    // Power-up image: LDI 0 / OUT / ADD 31 / JMP 1, with constant 1 at word 31.
    logic [7:0] data [0:MEM_DEPTH-1] = '{
        0:       8'hC0,
        1:       8'hE0,
        2:       8'h3F,
        3:       8'h81,
        31:      8'h01,
        default: 8'h00
    };

    assign rdata_a = data[raddr_a];
    assign rdata_b = data[raddr_b];

    always_ff @(posedge clk) begin
        if (we) begin
            data[waddr] <= wdata;
        end
    end
endmodule

// Memory wrapper. It gives the RAM array the stable hierarchical path m.m.data.
// Its ports pass straight through to the RAM.
module quick_cpu_mem #(
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic       clk,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [4:0] raddr_b,
    output logic [7:0] rdata_b
);
    quick_cpu_ram #(.MEM_DEPTH(MEM_DEPTH)) m (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );
endmodule

module tt_um_quick_cpu #(
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_JZ  = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_SYS = 3'd7;

    localparam logic [4:0] SYS_OUT = 5'd0;
    localparam logic [4:0] SYS_IN  = 5'd1;
    localparam logic [4:0] SYS_HLT = 5'd2;

    logic       rst;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [7:0] acc;
    logic [7:0] out_reg;
    state_t     state;
    logic       halted;

    logic [4:0] pc_d;
    logic [7:0] ir_d;
    logic [7:0] acc_d;
    logic [7:0] out_d;
    state_t     state_d;
    logic       halted_d;
    logic       mem_we;

    logic [2:0] op;
    logic [4:0] arg;
    logic [7:0] fetch_word;
    logic [7:0] operand;
    logic       zero;

    logic       unused_ok;

    assign rst       = ~rst_n;
    assign op        = ir[7:5];
    assign arg       = ir[4:0];
    assign zero      = (acc == 8'd0);
    assign unused_ok = &{1'b0, ena, uio_in};

    // Suppress the write on a reset edge so that reset aborts a pending STA.
    quick_cpu_mem #(.MEM_DEPTH(MEM_DEPTH)) m (
        .clk     (clk),
        .we      (mem_we & ~rst),
        .waddr   (arg),
        .wdata   (acc),
        .raddr_a (pc),
        .rdata_a (fetch_word),
        .raddr_b (arg),
        .rdata_b (operand)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= 5'd0;
            ir      <= 8'd0;
            acc     <= 8'd0;
            out_reg <= 8'd0;
            state   <= FETCH;
            halted  <= 1'b0;
        end else begin
            pc      <= pc_d;
            ir      <= ir_d;
            acc     <= acc_d;
            out_reg <= out_d;
            state   <= state_d;
            halted  <= halted_d;
        end
    end

    // Next-state and instruction execution. While halted, all state holds.
    always_comb begin
        pc_d     = pc;
        ir_d     = ir;
        acc_d    = acc;
        out_d    = out_reg;
        state_d  = state;
        halted_d = halted;
        mem_we   = 1'b0;
        if (!halted) begin
            unique case (state)
                FETCH: begin
                    ir_d    = fetch_word;
                    pc_d    = pc + 5'd1;
                    state_d = EXEC;
                end
                EXEC: begin
                    state_d = FETCH;
                    case (op)
                        OP_LDA: acc_d = operand;
                        OP_ADD: acc_d = acc + operand;
                        OP_SUB: acc_d = acc - operand;
                        OP_STA: mem_we = 1'b1;
                        OP_JMP: pc_d = arg;
                        OP_JZ: begin
                            if (zero) begin
                                pc_d = arg;
                            end
                        end
                        OP_LDI: acc_d = {3'b000, arg};
                        OP_SYS: begin
                            case (arg)
                                SYS_OUT: out_d    = acc;
                                SYS_IN:  acc_d    = ui_in;
                                SYS_HLT: halted_d = 1'b1;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = out_reg;
    assign uio_out = {halted, state == EXEC, zero, pc};
    assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_tt_um_quick_cpu.sv
// Testbench for tt_um_quick_cpu. An ISA-level model predicts uo_out, uio_out
// and uio_oe for every cycle through a scoreboard queue. Each scenario also
// ends with checks against fixed constants.
module tb_tt_um_quick_cpu;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_quick_cpu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0] mmem [0:31];
    logic [4:0] mpc;
    logic [7:0] mir;
    logic [7:0] macc;
    logic [7:0] mout;
    logic       mstate;
    logic       mhalt;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mpc = 5'd0; mir = 8'd0; macc = 8'd0; mout = 8'd0; mstate = 1'b0; mhalt = 1'b0;
    endtask

    task automatic model_step();
        logic [4:0] a;
        if (mhalt) return;
        if (!mstate) begin
            mir    = mmem[mpc];
            mpc    = mpc + 5'd1;
            mstate = 1'b1;
        end else begin
            a = mir[4:0];
            case (mir[7:5])
                3'd0: macc = mmem[a];
                3'd1: macc = macc + mmem[a];
                3'd2: macc = macc - mmem[a];
                3'd3: mmem[a] = macc;
                3'd4: mpc = a;
                3'd5: if (macc == 8'd0) mpc = a;
                3'd6: macc = {3'b000, a};
                default: begin
                    if (a == 5'd0) mout = macc;
                    else if (a == 5'd1) macc = ui_in;
                    else if (a == 5'd2) mhalt = 1'b1;
                end
            endcase
            mstate = 1'b0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.uo  = mout;
        e.uio = {mhalt, mstate, (macc == 8'd0), mpc};
        sb.push_back(e);
    endtask

    // Advance one clock and compare the DUT against the oldest expectation.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "_uo_out"}, uo_out, e.uo);
        check({tag, "_uio_out"}, uio_out, e.uio);
        check({tag, "_uio_oe"}, uio_oe, 8'hFF);
    endtask

    task automatic run(input int n, input string tag);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            model_step();
            push_expected();
            tick(tag);
        end
    endtask

    task automatic hold_reset(input int n, input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            model_reset();
            push_expected();
            tick(tag);
            check({tag, "_rst_status"}, uio_out, 8'h20);
        end
    endtask

    task automatic poke(input int addr, input logic [7:0] val);
        dut.m.m.data[addr] = val;
        mmem[addr] = val;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) poke(i, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
        mmem[0] = 8'hC0; mmem[1] = 8'hE0; mmem[2] = 8'h3F; mmem[3] = 8'h81; mmem[31] = 8'h01;

        // Default program from power-up contents
        hold_reset(2, "por");
        run(30, "default");
        check("default_final_out", uo_out, 8'h04);
        check("default_final_status", uio_out, 8'h03);

        // Mid-run reset restarts the same sequence
        run(5, "prerst");
        hold_reset(5, "midrst");
        run(12, "restart");
        check("restart_out", uo_out, 8'h01);

        // Arithmetic wrap: FF + 02 = 01
        rst_n = 1'b0;
        clear_mem();
        poke(0, 8'h10); poke(1, 8'h31); poke(2, 8'hE0); poke(3, 8'hE2);
        poke(16, 8'hFF); poke(17, 8'h02);
        hold_reset(2, "wraprst");
        run(12, "wrap");
        check("wrap_out", uo_out, 8'h01);
        check("wrap_halted_pc4", uio_out, 8'h84);
        check("wrap_pc_probe", 8'(dut.pc), 8'h04);

        // SUB / JZ taken
        rst_n = 1'b0;
        clear_mem();
        poke(0, 8'hC3); poke(1, 8'h5F); poke(2, 8'hA5); poke(3, 8'hE0); poke(4, 8'hE2);
        poke(5, 8'hC7); poke(6, 8'hE0); poke(7, 8'hE2); poke(31, 8'h03);
        hold_reset(2, "jzrst");
        run(16, "jz_taken");
        check("jz_taken_out", uo_out, 8'h07);

        // SUB / JZ not taken
        rst_n = 1'b0;
        poke(31, 8'h02);
        hold_reset(2, "jzrst2");
        run(16, "jz_not");
        check("jz_not_out", uo_out, 8'h01);

        // IN / STA round trip through RAM
        rst_n = 1'b0;
        clear_mem();
        ui_in = 8'hA5;
        poke(0, 8'hE1); poke(1, 8'h74); poke(2, 8'hC0); poke(3, 8'h14); poke(4, 8'hE0); poke(5, 8'hE2);
        hold_reset(2, "inrst");
        run(14, "in_sta");
        check("in_sta_out", uo_out, 8'hA5);
        check("in_sta_mem20", dut.m.m.data[20], 8'hA5);

        // PC wrap: JMP 31, NOP at 31, then the next fetch comes from 0
        rst_n = 1'b0;
        clear_mem();
        poke(0, 8'h9F); poke(31, 8'hE3);
        hold_reset(2, "pcrst");
        run(2, "pcwrap_a");
        check("pcwrap_at31", 8'(dut.pc), 8'h1F);
        run(1, "pcwrap_b");
        check("pcwrap_after_fetch31", uio_out, 8'h60);
        run(6, "pcwrap_c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
